// File: rtl/inst_encoder_if.sv
// Handshake bundle between a descriptor producer/word consumer and inst_encoder.
// The master side offers descriptors and accepts encoded words; the slave side is the encoder.
interface inst_encoder_if #(
  parameter int ERR_CNT_W = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [5:0]           in_op;
  logic [4:0]           in_rd;
  logic [4:0]           in_rs1;
  logic [4:0]           in_rs2;
  logic [31:0]          in_imm;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_inst;
  logic [63:0]          out_pc;
  logic                 out_err;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_inst, out_pc, out_err, err_count
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_inst, out_pc, out_err, err_count
  );
endinterface

// File: rtl/inst_encoder.sv
// inst_encoder: RV64IM descriptor to 32-bit machine word, two-stage elastic pipeline.
// Optional macro ENC_PSEUDO_EN turns ops 48-55 into pseudo-instructions.
module inst_encoder #(
  parameter logic [63:0] PC_BASE   = 64'h0,
  parameter int          ERR_CNT_W = 16
) (
  input  logic          clk,
  input  logic          reset,
  inst_encoder_if.slave bus
);

  localparam logic [2:0]  FMT_I  = 3'd0;
  localparam logic [2:0]  FMT_SH = 3'd1;
  localparam logic [2:0]  FMT_R  = 3'd2;
  localparam logic [2:0]  FMT_S  = 3'd3;
  localparam logic [2:0]  FMT_B  = 3'd4;
  localparam logic [2:0]  FMT_U  = 3'd5;
  localparam logic [2:0]  FMT_J  = 3'd6;
  localparam logic [2:0]  FMT_X  = 3'd7;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};
  localparam logic [ERR_CNT_W-1:0] ERR_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } desc_t;

  function automatic desc_t resolve(input logic [5:0] op, input logic [4:0] rd,
                                    input logic [4:0] rs1, input logic [4:0] rs2,
                                    input logic [31:0] imm);
    desc_t d;
    d.op = op; d.rd = rd; d.rs1 = rs1; d.rs2 = rs2; d.imm = imm;
`ifdef ENC_PSEUDO_EN
    case (op)
      6'd48:   begin d.op = 6'd0;  d.rd = 5'd0; d.rs1 = 5'd0; d.imm = 32'd0; end
      6'd49:   begin d.op = 6'd0;  d.imm = 32'd0; end
      6'd50:   begin d.op = 6'd3;  d.imm = 32'hFFFF_FFFF; end
      6'd51:   begin d.op = 6'd10; d.rs1 = 5'd0; end
      6'd52:   begin d.op = 6'd2;  d.imm = 32'd1; end
      6'd53:   begin d.op = 6'd46; d.rd = 5'd0; end
      6'd54:   begin d.op = 6'd47; d.rd = 5'd0; d.imm = 32'd0; end
      6'd55:   begin d.op = 6'd47; d.rd = 5'd0; d.rs1 = 5'd1; d.imm = 32'd0; end
      default: d.op = op;
    endcase
`endif
    return d;
  endfunction

  // Ops past 47 (after any pseudo expansion) fall out as FMT_X and are illegal.
  function automatic logic [2:0] fmt_of(input logic [5:0] op);
    if (op <= 6'd5)       return FMT_I;
    else if (op <= 6'd8)  return FMT_SH;
    else if (op <= 6'd26) return FMT_R;
    else if (op <= 6'd33) return FMT_I;
    else if (op <= 6'd37) return FMT_S;
    else if (op <= 6'd43) return FMT_B;
    else if (op <= 6'd45) return FMT_U;
    else if (op == 6'd46) return FMT_J;
    else if (op == 6'd47) return FMT_I;
    else                  return FMT_X;
  endfunction

  function automatic logic imm_ok(input logic [2:0] fmt, input logic [31:0] imm);
    case (fmt)
      FMT_I, FMT_S: return ($signed(imm) >= -32'sd2048) && ($signed(imm) <= 32'sd2047);
      FMT_SH:       return ($signed(imm) >= 32'sd0) && ($signed(imm) <= 32'sd63);
      FMT_B:        return ($signed(imm) >= -32'sd4096) && ($signed(imm) <= 32'sd4094) && (imm[0] == 1'b0);
      FMT_J:        return ($signed(imm) >= -32'sd1048576) && ($signed(imm) <= 32'sd1048574) && (imm[0] == 1'b0);
      FMT_U:        return ($signed(imm) >= 32'sd0) && ($signed(imm) <= 32'sd1048575);
      FMT_R:        return 1'b1;
      default:      return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] imm_scatter(input logic [2:0] fmt, input logic [31:0] imm);
    case (fmt)
      FMT_I:   return {imm[11:0], 20'h0};
      FMT_SH:  return {6'h0, imm[5:0], 20'h0};
      FMT_S:   return {imm[11:5], 13'h0, imm[4:0], 7'h0};
      FMT_B:   return {imm[12], imm[10:5], 13'h0, imm[4:1], imm[11], 7'h0};
      FMT_U:   return {imm[19:0], 12'h0};
      FMT_J:   return {imm[20], imm[10:1], imm[11], imm[19:12], 12'h0};
      default: return 32'h0;
    endcase
  endfunction

  // opcode | funct3 | funct7 for each base op; SRAI's bit 30 is folded in here.
  function automatic logic [31:0] base_bits(input logic [5:0] op);
    case (op)
      6'd0:  return 32'h0000_0013;  6'd1:  return 32'h0000_2013;
      6'd2:  return 32'h0000_3013;  6'd3:  return 32'h0000_4013;
      6'd4:  return 32'h0000_6013;  6'd5:  return 32'h0000_7013;
      6'd6:  return 32'h0000_1013;  6'd7:  return 32'h0000_5013;
      6'd8:  return 32'h4000_5013;  6'd9:  return 32'h0000_0033;
      6'd10: return 32'h4000_0033;  6'd11: return 32'h0000_1033;
      6'd12: return 32'h0000_2033;  6'd13: return 32'h0000_3033;
      6'd14: return 32'h0000_4033;  6'd15: return 32'h0000_5033;
      6'd16: return 32'h4000_5033;  6'd17: return 32'h0000_6033;
      6'd18: return 32'h0000_7033;  6'd19: return 32'h0200_0033;
      6'd20: return 32'h0200_1033;  6'd21: return 32'h0200_2033;
      6'd22: return 32'h0200_3033;  6'd23: return 32'h0200_4033;
      6'd24: return 32'h0200_5033;  6'd25: return 32'h0200_6033;
      6'd26: return 32'h0200_7033;  6'd27: return 32'h0000_0003;
      6'd28: return 32'h0000_1003;  6'd29: return 32'h0000_2003;
      6'd30: return 32'h0000_3003;  6'd31: return 32'h0000_4003;
      6'd32: return 32'h0000_5003;  6'd33: return 32'h0000_6003;
      6'd34: return 32'h0000_0023;  6'd35: return 32'h0000_1023;
      6'd36: return 32'h0000_2023;  6'd37: return 32'h0000_3023;
      6'd38: return 32'h0000_0063;  6'd39: return 32'h0000_1063;
      6'd40: return 32'h0000_4063;  6'd41: return 32'h0000_5063;
      6'd42: return 32'h0000_6063;  6'd43: return 32'h0000_7063;
      6'd44: return 32'h0000_0037;  6'd45: return 32'h0000_0017;
      6'd46: return 32'h0000_006F;  6'd47: return 32'h0000_0067;
      default: return NOP_WORD;
    endcase
  endfunction

  function automatic logic [31:0] reg_bits(input logic [2:0] fmt, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2);
    case (fmt)
      FMT_I, FMT_SH: return {12'h0, rs1, 3'h0, rd, 7'h0};
      FMT_R:         return {7'h0, rs2, rs1, 3'h0, rd, 7'h0};
      FMT_S, FMT_B:  return {7'h0, rs2, rs1, 3'h0, 5'h0, 7'h0};
      FMT_U, FMT_J:  return {20'h0, rd, 7'h0};
      default:       return 32'h0;
    endcase
  endfunction

  desc_t                in_desc_s;
  logic [2:0]           in_fmt_s;
  logic                 in_err_s;
  logic [31:0]          in_scat_s;
  logic                 s1_full_r;
  logic                 s1_err_r;
  logic [5:0]           s1_op_r;
  logic [4:0]           s1_rd_r;
  logic [4:0]           s1_rs1_r;
  logic [4:0]           s1_rs2_r;
  logic [31:0]          s1_imm_r;
  logic [2:0]           s1_fmt_s;
  logic [31:0]          s1_word_s;
  logic                 s2_full_r;
  logic                 s2_err_r;
  logic [31:0]          s2_inst_r;
  logic [63:0]          pc_r;
  logic [ERR_CNT_W-1:0] err_cnt_r;
  logic                 s2_free_s;
  logic                 s1_move_s;
  logic                 accept_s;
  logic                 handoff_s;

  assign s2_free_s    = !s2_full_r || bus.out_ready;
  assign s1_move_s    = s1_full_r && s2_free_s;
  assign bus.in_ready = !s1_full_r || s2_free_s;
  assign accept_s     = bus.in_valid && bus.in_ready;
  assign handoff_s    = s2_full_r && bus.out_ready;

  // Front-end decode: pseudo expansion, legality and immediate placement.
  always_comb begin
    in_desc_s = resolve(bus.in_op, bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_imm);
    in_fmt_s  = fmt_of(in_desc_s.op);
    in_err_s  = (in_fmt_s == FMT_X) || !imm_ok(in_fmt_s, in_desc_s.imm);
    in_scat_s = imm_scatter(in_fmt_s, in_desc_s.imm);
  end

  // Stage 1 register: resolved descriptor with its scattered immediate.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_full_r <= 1'b0;
      s1_err_r  <= 1'b0;
      s1_op_r   <= 6'd0;
      s1_rd_r   <= 5'd0;
      s1_rs1_r  <= 5'd0;
      s1_rs2_r  <= 5'd0;
      s1_imm_r  <= 32'd0;
    end else if (accept_s) begin
      s1_full_r <= 1'b1;
      s1_err_r  <= in_err_s;
      s1_op_r   <= in_desc_s.op;
      s1_rd_r   <= in_desc_s.rd;
      s1_rs1_r  <= in_desc_s.rs1;
      s1_rs2_r  <= in_desc_s.rs2;
      s1_imm_r  <= in_scat_s;
    end else if (s1_move_s) begin
      s1_full_r <= 1'b0;
    end
  end

  // Word assembly between the stages; illegal descriptors collapse to NOP.
  always_comb begin
    s1_fmt_s = fmt_of(s1_op_r);
    if (s1_err_r) begin
      s1_word_s = NOP_WORD;
    end else begin
      s1_word_s = base_bits(s1_op_r) | reg_bits(s1_fmt_s, s1_rd_r, s1_rs1_r, s1_rs2_r) | s1_imm_r;
    end
  end

  // Stage 2 register: word presented to the consumer, held while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_full_r <= 1'b0;
      s2_err_r  <= 1'b0;
      s2_inst_r <= 32'd0;
    end else if (s1_move_s) begin
      s2_full_r <= 1'b1;
      s2_err_r  <= s1_err_r;
      s2_inst_r <= s1_word_s;
    end else if (handoff_s) begin
      s2_full_r <= 1'b0;
    end
  end

  // Program address and saturating error tally, both advanced on handoff.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r      <= PC_BASE;
      err_cnt_r <= {ERR_CNT_W{1'b0}};
    end else if (handoff_s) begin
      pc_r <= pc_r + 64'd4;
      if (s2_err_r && (err_cnt_r != ERR_MAX)) begin
        err_cnt_r <= err_cnt_r + ERR_ONE;
      end
    end
  end

  assign bus.out_valid = s2_full_r;
  assign bus.out_inst  = s2_inst_r;
  assign bus.out_err   = s2_err_r;
  assign bus.out_pc    = pc_r;
  assign bus.err_count = err_cnt_r;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed scenarios plus a randomized stream
// scored against a field-arithmetic reference encoder and a queue model of the pipeline.
module tb_inst_encoder;
  localparam logic [63:0] PC_BASE   = 64'h0;
  localparam int          ERR_CNT_W = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  inst_encoder_if #(.ERR_CNT_W(ERR_CNT_W)) bus ();
  inst_encoder #(.PC_BASE(PC_BASE), .ERR_CNT_W(ERR_CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct { logic [31:0] inst; logic err; int acc; } exp_t;
  typedef struct { logic [31:0] inst; logic [63:0] pc; logic err; } got_t;

  exp_t        sb[$];
  got_t        got[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [63:0] m_pc = PC_BASE;
  int          m_errc = 0;

  int     alui_f3 [9]  = '{0, 2, 3, 4, 6, 7, 1, 5, 5};
  int     alu_f3  [10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
  int     br_f3   [6]  = '{0, 1, 4, 5, 6, 7};
  longint bnd     [18] = '{-1048577, -1048576, -4097, -4096, -2049, -2048, -1, 0, 1,
                           63, 64, 2047, 2048, 4094, 4095, 1048574, 1048575, 1048576};

  // Reference encoder: returns {err, word} from opcode tables and bit arithmetic.
  function automatic logic [32:0] ref_enc(input int op_in, input int rd_in, input int rs1_in,
                                          input int rs2_in, input longint imm_in);
    int op = op_in, rd = rd_in, rs1 = rs1_in, rs2 = rs2_in, kind = -1;
    longint imm = imm_in, opc = 0, f3 = 0, f7 = 0, w;
    bit ok = 1'b0;
`ifdef ENC_PSEUDO_EN
    if (op == 48) begin op = 0; rd = 0; rs1 = 0; imm = 0; end
    else if (op == 49) begin op = 0; imm = 0; end
    else if (op == 50) begin op = 3; imm = -1; end
    else if (op == 51) begin op = 10; rs1 = 0; end
    else if (op == 52) begin op = 2; imm = 1; end
    else if (op == 53) begin op = 46; rd = 0; end
    else if (op == 54) begin op = 47; rd = 0; imm = 0; end
    else if (op == 55) begin op = 47; rd = 0; rs1 = 1; imm = 0; end
`endif
    if (op <= 5)       begin kind = 0; opc = 19; f3 = alui_f3[op]; end
    else if (op <= 8)  begin kind = 1; opc = 19; f3 = alui_f3[op]; f7 = (op == 8) ? 32 : 0; end
    else if (op <= 18) begin kind = 2; opc = 51; f3 = alu_f3[op-9]; f7 = (op == 10 || op == 16) ? 32 : 0; end
    else if (op <= 26) begin kind = 2; opc = 51; f3 = op - 19; f7 = 1; end
    else if (op <= 33) begin kind = 0; opc = 3; f3 = op - 27; end
    else if (op <= 37) begin kind = 3; opc = 35; f3 = op - 34; end
    else if (op <= 43) begin kind = 4; opc = 99; f3 = br_f3[op-38]; end
    else if (op == 44) begin kind = 5; opc = 55; end
    else if (op == 45) begin kind = 5; opc = 23; end
    else if (op == 46) begin kind = 6; opc = 111; end
    else if (op == 47) begin kind = 0; opc = 103; end
    w = opc + (f3 << 12) + (f7 << 25);
    if (kind inside {0, 1, 2, 5, 6}) w += longint'(rd) << 7;
    if (kind inside {0, 1, 2, 3, 4}) w += longint'(rs1) << 15;
    if (kind inside {2, 3, 4})       w += longint'(rs2) << 20;
    case (kind)
      0: begin ok = imm >= -2048 && imm <= 2047; w += (imm & 'hFFF) << 20; end
      1: begin ok = imm >= 0 && imm <= 63; w += (imm & 63) << 20; end
      2: ok = 1'b1;
      3: begin ok = imm >= -2048 && imm <= 2047;
               w += (((imm >> 5) & 127) << 25) + ((imm & 31) << 7); end
      4: begin ok = imm >= -4096 && imm <= 4094 && (imm % 2 == 0);
               w += (((imm >> 12) & 1) << 31) + (((imm >> 5) & 63) << 25)
                  + (((imm >> 1) & 15) << 8) + (((imm >> 11) & 1) << 7); end
      5: begin ok = imm >= 0 && imm <= 1048575; w += (imm & 'hFFFFF) << 12; end
      6: begin ok = imm >= -1048576 && imm <= 1048574 && (imm % 2 == 0);
               w += (((imm >> 20) & 1) << 31) + (((imm >> 1) & 1023) << 21)
                  + (((imm >> 11) & 1) << 20) + (((imm >> 12) & 255) << 12); end
      default: ok = 1'b0;
    endcase
    if (!ok) return {1'b1, 32'h0000_0013};
    return {1'b0, w[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int op, input int rd, input int rs1,
                       input int rs2, input longint imm);
    bus.in_valid = v;
    bus.in_op    = op[5:0];
    bus.in_rd    = rd[4:0];
    bus.in_rs1   = rs1[4:0];
    bus.in_rs2   = rs2[4:0];
    bus.in_imm   = imm[31:0];
  endtask

  // One clock: check outputs against the queue model, then advance model and clock.
  task automatic tick();
    logic  exp_ir, exp_ov;
    logic [32:0] r;
    #1;
    if (reset) begin
      @(posedge clk);
      sb.delete();
      m_pc   = PC_BASE;
      m_errc = 0;
    end else begin
      exp_ir = (sb.size() < 2) || bus.out_ready;
      exp_ov = (sb.size() > 0) && (cyc >= sb[0].acc + 2);
      chk("in_ready", bus.in_ready, exp_ir);
      chk("out_valid", bus.out_valid, exp_ov);
      chk("out_pc", bus.out_pc, m_pc);
      chk("err_count", bus.err_count, m_errc);
      if (exp_ov && bus.out_valid) begin
        chk("out_inst", bus.out_inst, sb[0].inst);
        chk("out_err", bus.out_err, sb[0].err);
      end
      if (exp_ov && bus.out_ready) begin
        got.push_back('{bus.out_inst, bus.out_pc, bus.out_err});
        if (sb[0].err && m_errc < (1 << ERR_CNT_W) - 1) m_errc++;
        void'(sb.pop_front());
        m_pc = m_pc + 64'd4;
      end
      if (bus.in_valid && exp_ir) begin
        r = ref_enc(int'(bus.in_op), int'(bus.in_rd), int'(bus.in_rs1), int'(bus.in_rs2),
                    longint'($signed(bus.in_imm)));
        sb.push_back('{r[31:0], r[32], cyc});
      end
      @(posedge clk);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    reset = 1'b0;
    got.delete();
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed=time limit expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus.out_ready = 1'b0;
    drive(1'b0, 0, 0, 0, 0, 0);
    @(negedge clk);
    tick();
    do_reset();
    chk("rst_out_inst", bus.out_inst, 32'h0);
    chk("rst_out_err", bus.out_err, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);

    // ADDI x10, x0, 5
    bus.out_ready = 1'b1;
    drive(1'b1, 0, 10, 0, 0, 5);
    tick();
    idle(4);
    chk("addi_count", got.size(), 1);
    if (got.size() >= 1) begin
      chk("addi_inst", got[0].inst, 32'h0050_0513);
      chk("addi_err", got[0].err, 1'b0);
      chk("addi_pc", got[0].pc, PC_BASE);
    end

    // SD then JAL back-to-back
    do_reset();
    bus.out_ready = 1'b1;
    drive(1'b1, 37, 0, 2, 1, 8);
    tick();
    drive(1'b1, 46, 1, 0, 0, -4);
    tick();
    idle(4);
    chk("sdjal_count", got.size(), 2);
    if (got.size() >= 2) begin
      chk("sd_inst", got[0].inst, 32'h0011_3423);
      chk("sd_pc", got[0].pc, PC_BASE);
      chk("jal_inst", got[1].inst, 32'hFFDF_F0EF);
      chk("jal_pc", got[1].pc, PC_BASE + 64'd4);
    end

    // Illegal immediates
    do_reset();
    bus.out_ready = 1'b1;
    drive(1'b1, 0, 1, 1, 0, 2048);
    tick();
    drive(1'b1, 38, 0, 1, 2, 3);
    tick();
    idle(4);
    chk("illegal_count", got.size(), 2);
    if (got.size() >= 2) begin
      chk("ill0_inst", got[0].inst, 32'h0000_0013);
      chk("ill0_err", got[0].err, 1'b1);
      chk("ill1_inst", got[1].inst, 32'h0000_0013);
      chk("ill1_err", got[1].err, 1'b1);
    end
    chk("ill_err_count", bus.err_count, 2);

    // Backpressure with three descriptors offered
    do_reset();
    bus.out_ready = 1'b0;
    drive(1'b1, 9, 1, 2, 3, 0);
    tick();
    drive(1'b1, 44, 5, 0, 0, 'h12345);
    tick();
    drive(1'b1, 39, 0, 4, 5, -8);
    tick();
    tick();
    #1;
    chk("bp_in_ready", bus.in_ready, 1'b0);
    chk("bp_hold_inst", bus.out_inst, 32'h0031_00B3);
    tick();
    bus.out_ready = 1'b1;
    tick();
    idle(5);
    chk("bp_count", got.size(), 3);
    if (got.size() >= 3) begin
      chk("bp0_inst", got[0].inst, 32'h0031_00B3);
      chk("bp1_inst", got[1].inst, 32'h1234_52B7);
      chk("bp2_inst", got[2].inst, 32'hFE52_1CE3);
      chk("bp0_pc", got[0].pc, PC_BASE);
      chk("bp1_pc", got[1].pc, PC_BASE + 64'd4);
      chk("bp2_pc", got[2].pc, PC_BASE + 64'd8);
    end

    // Reset with two descriptors buffered after one error word was handed off
    do_reset();
    bus.out_ready = 1'b1;
    drive(1'b1, 0, 1, 1, 0, 4096);
    tick();
    idle(3);
    bus.out_ready = 1'b0;
    drive(1'b1, 9, 1, 2, 3, 0);
    tick();
    drive(1'b1, 10, 4, 5, 6, 0);
    tick();
    idle(2);
    do_reset();
    chk("mrst_out_valid", bus.out_valid, 1'b0);
    chk("mrst_out_pc", bus.out_pc, PC_BASE);
    chk("mrst_err_count", bus.err_count, 0);
    bus.out_ready = 1'b1;
    drive(1'b1, 0, 3, 0, 0, 7);
    tick();
    idle(3);
    chk("mrst_count", got.size(), 1);
    if (got.size() >= 1) chk("mrst_pc", got[0].pc, PC_BASE);

    // RET (op 55)
    do_reset();
    bus.out_ready = 1'b1;
    drive(1'b1, 55, 9, 9, 9, 0);
    tick();
    idle(3);
    chk("ret_count", got.size(), 1);
    if (got.size() >= 1) begin
`ifdef ENC_PSEUDO_EN
      chk("ret_inst", got[0].inst, 32'h0000_8067);
      chk("ret_err", got[0].err, 1'b0);
`else
      chk("ret_inst", got[0].inst, 32'h0000_0013);
      chk("ret_err", got[0].err, 1'b1);
`endif
    end

    // Randomized stream with random backpressure and occasional reset
    do_reset();
    for (int i = 0; i < 800; i++) begin
      longint imm;
      case ($urandom_range(0, 3))
        0: imm = bnd[$urandom_range(0, 17)];
        1: imm = longint'($urandom_range(0, 200)) - 100;
        2: imm = longint'($urandom_range(0, 4200)) - 2100;
        default: imm = longint'($signed($urandom()));
      endcase
      bus.out_ready = ($urandom_range(0, 2) != 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 63), $urandom_range(0, 31),
            $urandom_range(0, 31), $urandom_range(0, 31), imm);
      reset = ($urandom_range(0, 199) == 0);
      tick();
      reset = 1'b0;
    end
    bus.out_ready = 1'b1;
    idle(6);
    #1;
    chk("drain_out_valid", bus.out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
Encodes symbolic RV64IM instruction descriptors into 32-bit machine words. This is the inverse of the instruction disassembler/decoder. It feeds the instruction-memory loader and the self-check test generators. Input and output use valid/ready handshakes through a 2-stage elastic pipeline. Each emitted word carries its program address and an encoding-error flag.

Parameters:
PC_BASE, 64'h0, address assigned to the first emitted word after reset
ERR_CNT_W, 16, width of the saturating error counter

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  descriptor valid
in_ready  out  1  encoder can accept a descriptor
in_op  in  6  operation code (see Behaviour)
in_rd  in  5  destination register index
in_rs1  in  5  source register 1 index
in_rs2  in  5  source register 2 index
in_imm  in  32  signed immediate / offset, or the U-type upper value
out_valid  out  1  encoded word valid
out_ready  in  1  consumer accepts the word
out_inst  out  32  encoded instruction
out_pc  out  64  address of out_inst
out_err  out  1  descriptor was illegal; out_inst is the canonical NOP
err_count  out  ERR_CNT_W  number of error words handed off, saturating

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: in_ready=1, out_valid=0, out_inst=0, out_err=0, out_pc=PC_BASE, err_count=0. Both pipeline stages are empty.
- Reset mid-operation: descriptors held in either stage are dropped, with no output handshake.

op codes:
- 0-8: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI
- 9-18: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND
- 19-26: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
- 27-33: LB, LH, LW, LD, LBU, LHU, LWU
- 34-37: SB, SH, SW, SD
- 38-43: BEQ, BNE, BLT, BGE, BLTU, BGEU
- 44-47: LUI, AUIPC, JAL, JALR
- 48-63: reserved, see Optional Feature

Encoding and legality rules:
- Fields use standard RV64 opcode/funct3/funct7 placement. Register fields the format does not use are ignored.
- I, S and load formats: in_imm must lie in -2048..2047.
- Shifts: 0 <= in_imm <= 63; shamt goes to bits [25:20]. SRAI sets bit 30.
- B format: in_imm must lie in -4096..4094 and be even.
- J format: in_imm must lie in -1048576..1048574 and be even.
- U format: in_imm must lie in 0..0xFFFFF; it is placed in bits [31:12].
- Illegal op or out-of-range immediate: out_inst=32'h00000013 and out_err=1.

Pipeline:
- S1 registers the descriptor and computes legality plus the immediate scatter.
- S2 holds the assembled word.
- Latency: a descriptor accepted in cycle N presents out_valid in cycle N+2 when there is no backpressure. Throughput is 1 word per cycle.
- in_ready = !S1_full || (!S2_full || out_ready). This is combinational from out_ready; no other combinational input-to-output path exists.
- While out_valid=1 and out_ready=0: out_inst, out_pc and out_err hold stable. Up to 2 descriptors may be buffered, then in_ready=0.
- Ordering is strictly FIFO; no descriptor is lost or duplicated.

Address and error counter:
- On each out_valid && out_ready, out_pc advances by 4 in the following cycle; it wraps modulo 2^64.
- err_count increments on handoff of an out_err=1 word and saturates at all-ones.
- Simultaneous accept and handoff in the same cycle are both honoured.

Optional Feature:
- Macro: ENC_PSEUDO_EN
- Defined: ops 48-55 are pseudo-instructions, expanded to a single base word:
  - NOP -> addi x0,x0,0
  - MV -> addi rd,rs1,0
  - NOT -> xori rd,rs1,-1
  - NEG -> sub rd,x0,rs2
  - SEQZ -> sltiu rd,rs1,1
  - J -> jal x0,imm
  - JR -> jalr x0,0(rs1)
  - RET -> jalr x0,0(x1)
  - Pseudo-ops obey the same legality rules as their expansion.
- Not defined: ops 48-63 are illegal (NOP word, out_err=1).

Test Plan:
- ADDI rd=10, rs1=0, imm=5, out_ready=1 -> out_inst=0x00500513, out_err=0, out_pc=0, out_valid exactly 2 cycles after acceptance.
- SD rs2=1, rs1=2, imm=8, then JAL rd=1, imm=-4 back-to-back -> 0x00113423 at pc 0, then 0xFFDFF0EF at pc 4.
- ADDI imm=2048, then BEQ imm=3 -> two 0x00000013 words with out_err=1; err_count=2.
- out_ready=0 with 3 descriptors offered:
  - in_ready drops after 2 are accepted; outputs stay stable.
  - Releasing out_ready yields the 3 words in order at pc 0, 4, 8.
- Reset asserted for 1 cycle while 2 descriptors are buffered -> next cycle out_valid=0, out_pc=PC_BASE, err_count=0; the next word is at PC_BASE.
- Op 55 (RET): with ENC_PSEUDO_EN -> 0x00008067, out_err=0; without it -> 0x00000013, out_err=1.
